mem_arbiter_rr: RTL and testbench

Parametrised multi-core memory arbiter that sits between NCORES processor cores and one single-port synchronous RAM. It replaces the fixed two-core, fixed-priority controller with round-robin arbitration, configurable address and data widths, and a configurable RAM read latency. Each access uses a per-transaction request/ack handshake with a one-cycle ack pulse. Read data is held per core until that core's next read.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/mem_arbiter_rr.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the round-robin memory arbiter:
//   - arb_state_e : arbiter FSM state encoding (IDLE, XFER, WAIT, ACK)
//   - LAT_CW      : width of the read-latency down-counter
//   - slice_lo    : low bit of a per-core slice in a flattened bus
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } arb_state_e;

  localparam int MIN_CORES  = 2;
  localparam int MAX_CORES  = 8;
  localparam int MAX_RD_LAT = 3;

  // Holds RD_LAT-1 at most, so it must reach MAX_RD_LAT-1.
  localparam int LAT_CW = $clog2(MAX_RD_LAT + 1);

  // Core idx owns bits [slice_lo(idx, width) +: width] of a flattened bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches the request vector starting
// at the pointer index and wrapping, and returns the first set request.
// Ports:
//   req_i   : request vector, one bit per core
//   ptr_i   : highest-priority index for this search
//   gnt_o   : one-hot winner (zero when no request)
//   valid_o : at least one request present
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter  int NCORES = 4,
  localparam int PW     = $clog2(NCORES)
) (
  input  logic [NCORES-1:0] req_i,
  input  logic [PW-1:0]     ptr_i,
  output logic [NCORES-1:0] gnt_o,
  output logic              valid_o
);

  logic          found;
  logic [PW-1:0] idx;

  // Walk ptr, ptr+1, ... modulo NCORES; the first hit wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NCORES; k++) begin
      idx = PW'((int'(ptr_i) + k) % NCORES);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
// Round-robin arbiter giving NCORES cores access to one single-port
// synchronous RAM. Each access is a request/ack handshake: the winner's
// address, data and write flag are latched at grant, a write completes
// after one XFER cycle, a read waits RD_LAT cycles for ram_q, then a
// one-cycle ack pulse returns to the core. Read data is held per core.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   rden_i, wren_i      : per-core read / write request (write wins)
//   addr_i, din_i       : per-core address / write data, flattened
//   dq_o                : per-core read data, flattened
//   ack_o               : per-core one-cycle completion pulse
//   ram_addr_o, ram_din_o, ram_wren_o, ram_q_i : RAM port
//   busy_o              : high whenever a transaction is in progress
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCORES-1:0]    rden_i,
  input  logic [NCORES-1:0]    wren_i,
  input  logic [NCORES*AW-1:0] addr_i,
  input  logic [NCORES*DW-1:0] din_i,
  output logic [NCORES*DW-1:0] dq_o,
  output logic [NCORES-1:0]    ack_o,
  output logic [AW-1:0]        ram_addr_o,
  output logic [DW-1:0]        ram_din_o,
  output logic                 ram_wren_o,
  input  logic [DW-1:0]        ram_q_i,
  output logic                 busy_o
);

  localparam int PW = $clog2(NCORES);

  arb_state_e          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic                isw_q, isw_d;
  logic [LAT_CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]       ram_addr_q, ram_addr_d;
  logic [DW-1:0]       ram_din_q, ram_din_d;
  logic                ram_wren_q, ram_wren_d;
  logic [NCORES*DW-1:0] dq_q, dq_d;

  logic [NCORES-1:0]   req;
  logic [NCORES-1:0]   pick_gnt;
  logic                pick_valid;
  logic [PW-1:0]       pick_idx;

  assign req = rden_i | wren_i;

  rr_pick #(
    .NCORES (NCORES)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  // Binary index of the one-hot winner.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (pick_gnt[i]) pick_idx = PW'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      isw_q      <= 1'b0;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_wren_q <= 1'b0;
      dq_q       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      isw_q      <= isw_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_wren_q <= ram_wren_d;
      dq_q       <= dq_d;
    end
  end

  // ram_wren defaults low so it is high only in the XFER cycle of a write.
  // The core's slice is sampled once at grant; later changes are ignored.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    isw_d      = isw_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_wren_d = 1'b0;
    dq_d       = dq_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d    = S_XFER;
          gidx_d     = pick_idx;
          isw_d      = wren_i[pick_idx];
          ram_wren_d = wren_i[pick_idx];
          ram_addr_d = addr_i[slice_lo(int'(pick_idx), AW) +: AW];
          ram_din_d  = din_i[slice_lo(int'(pick_idx), DW) +: DW];
          ptr_d      = (pick_idx == PW'(NCORES - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      S_XFER: begin
        if (isw_q) begin
          state_d = S_ACK;
        end else begin
          state_d = S_WAIT;
          cnt_d   = LAT_CW'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          dq_d[slice_lo(int'(gidx_q), DW) +: DW] = ram_q_i;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ack_o      = (state_q == S_ACK) ? (NCORES'(1) << gidx_q) : '0;
  assign busy_o     = (state_q != S_IDLE);
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
  assign ram_wren_o = ram_wren_q;
  assign dq_o       = dq_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr
// Bench for mem_arbiter_rr (NCORES=4, AW=8, DW=8, RD_LAT=2) with a
// latency-accurate RAM model, plus a standalone table test of rr_pick.
// A transaction-timeline reference model predicts every output each cycle.
module tb_mem_arbiter_rr;

  localparam int NC  = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int RDL = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     rden, wren;
  logic [NC*AW-1:0]  addr;
  logic [NC*DW-1:0]  din;
  logic [NC*DW-1:0]  dq;
  logic [NC-1:0]     ack;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_din;
  logic              ram_wren;
  logic [DW-1:0]     ram_q;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_rr #(
    .NCORES (NC), .AW (AW), .DW (DW), .RD_LAT (RDL)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rden_i     (rden),
    .wren_i     (wren),
    .addr_i     (addr),
    .din_i      (din),
    .dq_o       (dq),
    .ack_o      (ack),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_wren_o (ram_wren),
    .ram_q_i    (ram_q),
    .busy_o     (busy)
  );

  // Standalone picker under table test.
  logic [NC-1:0] t_req, t_gnt;
  logic [1:0]    t_ptr;
  logic          t_vld;

  rr_pick #(.NCORES (NC)) u_pick (
    .req_i   (t_req),
    .ptr_i   (t_ptr),
    .gnt_o   (t_gnt),
    .valid_o (t_vld)
  );

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  // RAM model: contents reload to a known pattern under reset, read data
  // appears RDL cycles after the address is presented.
  logic [7:0] ram [256];
  logic [7:0] pipe [RDL];

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 256; a++) ram[a] <= pat(a);
    end else if (ram_wren) begin
      ram[ram_addr] <= ram_din;
    end
    pipe[0] <= ram[ram_addr];
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end

  assign ram_q = pipe[RDL-1];

  // Reference model: one transaction at a time, described by its grant
  // edge and its ack edge; the pointer advances past each winner.
  int         pidx = 0;
  bit         act = 1'b0;
  bit         m_wr;
  int         m_g, m_gp, m_ackp;
  int         ptr = 0;
  logic [7:0] m_rdata;
  logic [7:0] e_dq [NC];
  logic [7:0] e_addr, e_din;
  logic [7:0] mem_ref [256];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, pidx);
    end
  endtask

  task automatic model_step();
    logic [NC-1:0] req;
    int w;
    pidx++;
    req = rden | wren;
    if (rst) begin
      act    = 1'b0;
      ptr    = 0;
      e_addr = '0;
      e_din  = '0;
      for (int i = 0; i < NC; i++) e_dq[i] = '0;
      for (int a = 0; a < 256; a++) mem_ref[a] = pat(a);
    end else if (act) begin
      if (pidx == m_ackp && !m_wr) e_dq[m_g] = m_rdata;
      if (pidx == m_ackp + 1) act = 1'b0;
    end else if (req != 0) begin
      w = -1;
      for (int k = 0; k < NC; k++)
        if (w < 0 && req[(ptr + k) % NC]) w = (ptr + k) % NC;
      m_g    = w;
      m_wr   = wren[w];
      m_gp   = pidx;
      m_ackp = m_wr ? pidx + 1 : pidx + 1 + RDL;
      e_addr = addr[w*AW +: AW];
      e_din  = din[w*DW +: DW];
      if (m_wr) mem_ref[e_addr] = e_din;
      else      m_rdata = mem_ref[e_addr];
      ptr = (w + 1) % NC;
      act = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [NC-1:0] e_ack;
    e_ack = (act && pidx == m_ackp) ? NC'(1) << m_g : '0;
    chk("busy", busy, act);
    chk("ack", ack, e_ack);
    chk("ram_wren", ram_wren, act && m_wr && pidx == m_gp);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_din", ram_din, e_din);
    for (int i = 0; i < NC; i++) chk($sformatf("dq%0d", i), dq[i*DW +: DW], e_dq[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic applyStimulus(input int c, input bit rd, input bit wr,
                               input logic [7:0] a, input logic [7:0] d);
    rden[c] = rd;
    wren[c] = wr;
    addr[c*AW +: AW] = a;
    din[c*DW +: DW]  = d;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && act; k++) tick();
    chk("drain_idle", act, 1'b0);
  endtask

  typedef struct {
    logic [NC-1:0] req;
    logic [1:0]    ptr;
    logic [NC-1:0] gnt;
    logic          vld;
  } pick_vec_t;

  pick_vec_t pv [10];
  int        got [$];
  int        exp_order [5];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; rden = '0; wren = '0; addr = '0; din = '0;

    // rr_pick table
    pv[0] = '{4'b0000, 2'd0, 4'b0000, 1'b0};
    pv[1] = '{4'b0001, 2'd0, 4'b0001, 1'b1};
    pv[2] = '{4'b1111, 2'd0, 4'b0001, 1'b1};
    pv[3] = '{4'b1111, 2'd2, 4'b0100, 1'b1};
    pv[4] = '{4'b1111, 2'd3, 4'b1000, 1'b1};
    pv[5] = '{4'b0011, 2'd2, 4'b0001, 1'b1};
    pv[6] = '{4'b0110, 2'd3, 4'b0010, 1'b1};
    pv[7] = '{4'b1001, 2'd1, 4'b1000, 1'b1};
    pv[8] = '{4'b1010, 2'd2, 4'b1000, 1'b1};
    pv[9] = '{4'b0100, 2'd3, 4'b0100, 1'b1};
    for (int i = 0; i < 10; i++) begin
      t_req = pv[i].req;
      t_ptr = pv[i].ptr;
      #1;
      chk($sformatf("pick_gnt[%0d]", i), t_gnt, pv[i].gnt);
      chk($sformatf("pick_vld[%0d]", i), t_vld, pv[i].vld);
    end

    // Reset state
    @(negedge clk);
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_dq", dq, 32'h0);
    chk("rst_ram_addr", ram_addr, 8'h00);
    rst = 1'b0;
    tick();

    // Core 0 writes 0x12 <- 0xA5
    applyStimulus(0, 1'b0, 1'b1, 8'h12, 8'hA5);
    tick();
    chk("wr_t1_wren", ram_wren, 1'b1);
    chk("wr_t1_addr", ram_addr, 8'h12);
    chk("wr_t1_din", ram_din, 8'hA5);
    tick();
    chk("wr_t2_ack", ack, 4'b0001);
    applyStimulus(0, 1'b0, 1'b0, 8'h12, 8'hA5);
    tick();
    chk("wr_t3_busy", busy, 1'b0);

    // Core 0 reads 0x12
    applyStimulus(0, 1'b1, 1'b0, 8'h12, 8'h00);
    tick(); tick(); tick();
    chk("rd_t3_ack", ack, 4'b0000);
    tick();
    chk("rd_t4_ack", ack, 4'b0001);
    chk("rd_t4_dq0", dq[7:0], 8'hA5);
    chk("rd_t4_dq_others", dq[31:8], 24'h0);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drain();

    // All cores requesting continuously from reset
    rst = 1'b1;
    for (int c = 0; c < NC; c++) applyStimulus(c, 1'b0, 1'b1, 8'(8'h80 + c), 8'(c));
    tick();
    rst = 1'b0;
    got.delete();
    exp_order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 40 && got.size() < 5; k++) begin
      tick();
      for (int j = 0; j < NC; j++) if (ack[j]) got.push_back(j);
    end
    wren = '0;
    chk("rr_count", got.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_order[%0d]", i), (i < got.size()) ? got[i] : 99, exp_order[i]);
    drain();

    // Core 2 read to give dq2 a known value
    applyStimulus(2, 1'b1, 1'b0, 8'h33, 8'h00);
    for (int k = 0; k < 10 && !ack[2]; k++) tick();
    chk("c2_rd_dq2", dq[23:16], 8'h69);
    applyStimulus(2, 1'b0, 1'b0, 8'h33, 8'h00);
    drain();

    // Core 2 with rden and wren together is a write
    applyStimulus(2, 1'b1, 1'b1, 8'h20, 8'h3C);
    tick();
    chk("both_wren", ram_wren, 1'b1);
    chk("both_din", ram_din, 8'h3C);
    tick();
    chk("both_ack", ack, 4'b0100);
    chk("both_dq2", dq[23:16], 8'h69);
    applyStimulus(2, 1'b0, 1'b0, 8'h20, 8'h3C);
    drain();

    // Core 1 read, addr changed and rden dropped during WAIT; core 2 pending
    applyStimulus(1, 1'b1, 1'b0, 8'h40, 8'h00);
    applyStimulus(2, 1'b0, 1'b1, 8'h50, 8'h77);
    tick();
    chk("chg_grant_addr", ram_addr, 8'h40);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 8'h41, 8'h00);
    tick();
    chk("chg_hold_addr", ram_addr, 8'h40);
    tick();
    chk("chg_ack", ack, 4'b0010);
    chk("chg_dq1", dq[15:8], 8'h1A);
    tick(); tick();
    chk("chg_next_addr", ram_addr, 8'h50);
    chk("chg_next_wren", ram_wren, 1'b1);
    tick();
    chk("chg_next_ack", ack, 4'b0100);
    applyStimulus(2, 1'b0, 1'b0, 8'h50, 8'h77);
    drain();

    // Reset during XFER of a write
    applyStimulus(2, 1'b0, 1'b1, 8'h60, 8'h11);
    tick();
    chk("rx_xfer_wren", ram_wren, 1'b1);
    rst = 1'b1;
    applyStimulus(2, 1'b0, 1'b0, 8'h60, 8'h11);
    tick();
    chk("rx_wren", ram_wren, 1'b0);
    chk("rx_ack", ack, 4'b0000);
    chk("rx_busy", busy, 1'b0);
    rst = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 8'h70, 8'h00);
    applyStimulus(3, 1'b1, 1'b0, 8'h73, 8'h00);
    tick();
    chk("rx_ptr0_addr", ram_addr, 8'h70);
    for (int k = 0; k < 40; k++) begin
      if (ack[0]) rden[0] = 1'b0;
      if (ack[3]) rden[3] = 1'b0;
      if (rden == 0 && !act) break;
      tick();
    end
    chk("rx_drain", rden, 4'b0000);

    // Randomized traffic, driven from the model's view of each transaction
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(399, 0) == 0);
      for (int i = 0; i < NC; i++) begin
        if (act && m_g == i && pidx == m_ackp) begin
          if ($urandom_range(1, 0) == 1)
            applyStimulus(i, 1'b1, ($urandom_range(2, 0) == 0), 8'($urandom), 8'($urandom));
          else
            applyStimulus(i, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
        end else if (act && m_g == i) begin
          if ($urandom_range(7, 0) == 0) begin
            addr[i*AW +: AW] = 8'($urandom);
            din[i*DW +: DW]  = 8'($urandom);
          end
          if ($urandom_range(15, 0) == 0) begin
            rden[i] = 1'b0;
            wren[i] = 1'b0;
          end
        end else if (!(rden[i] | wren[i]) && $urandom_range(3, 0) == 0) begin
          applyStimulus(i, ($urandom_range(1, 0) == 1), ($urandom_range(2, 0) == 0),
                        8'($urandom), 8'($urandom));
          if (!(rden[i] | wren[i])) rden[i] = 1'b1;
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
